// File: rtl/hazard_controller_pkg.sv
// Shared types and sizing for the issue-stage hazard controller.
package hazard_controller_pkg;

    localparam int REG_ADDR_WIDTH         = 5;
    localparam int REG_FILE_SIZE          = 1 << REG_ADDR_WIDTH;
    localparam int BYPASS_DEPTH           = 2;
    localparam int BYPASS_READ_PORT_COUNT = 2;
    // The hazard checker and the bypass muxes must agree on port count.
    localparam int READ_PORT_COUNT        = BYPASS_READ_PORT_COUNT;
    localparam int BYPASS_SEL_WIDTH       = $clog2(BYPASS_DEPTH + 1);

    typedef logic [REG_ADDR_WIDTH-1:0]   reg_addr_t;
    typedef logic [BYPASS_SEL_WIDTH-1:0] BypassSel;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
    } BypassStage;

endpackage

// File: rtl/hazard_controller_if.sv
// Issue-side bundle between the issue stage and the hazard controller.
interface hazard_controller_if;
    import hazard_controller_pkg::*;

    logic                                 issueValid;
    reg_addr_t [READ_PORT_COUNT-1:0]      issueRs;
    logic      [READ_PORT_COUNT-1:0]      issueRsRead;
    reg_addr_t                            issueRd;
    logic                                 issueRdWrite;
    logic                                 issueLongLatency;
    logic                                 issueReady;
    BypassSel  [READ_PORT_COUNT-1:0]      bypassSel;

    modport master (
        output issueValid, issueRs, issueRsRead, issueRd, issueRdWrite, issueLongLatency,
        input  issueReady, bypassSel
    );

    modport slave (
        input  issueValid, issueRs, issueRsRead, issueRd, issueRdWrite, issueLongLatency,
        output issueReady, bypassSel
    );

endinterface

// File: rtl/hazard_controller_pending_table.sv
// Scoreboard of registers with an outstanding long-latency write.
module pending_table
    import hazard_controller_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstIn,
    input  logic                     set,
    input  reg_addr_t                setAddr,
    input  logic                     clear,
    input  reg_addr_t                clearAddr,
    output logic [REG_FILE_SIZE-1:0] pending
);

    logic [REG_FILE_SIZE-1:0] pendingNext;

    // Apply clear then set so a same-register collision leaves the bit set; x0 never pends.
    always_comb begin
        pendingNext = pending;
        if (clear) begin
            pendingNext[clearAddr] = 1'b0;
        end
        if (set) begin
            pendingNext[setAddr] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    // Scoreboard register, emptied by reset.
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Issue-stage hazard controller: RAW/WAW stall against pending long-latency
// writes, bypass select generation and pipeline-busy reporting.
module hazard_controller
    import hazard_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rstIn,
    hazard_controller_if.slave  issue,
    input  logic                flush,
    input  logic                wbValid,
    input  reg_addr_t           wbRd,
    output logic                busy
);

    logic [REG_FILE_SIZE-1:0]        pending;
    BypassStage                      stages [BYPASS_DEPTH];
    BypassSel [READ_PORT_COUNT-1:0]  selNext;
    logic                            hazard;
    logic                            fire;
    logic                            setPending;
    logic                            bypassWrite;
    logic                            anyStageValid;

    pending_table u_pending_table (
        .clk       (clk),
        .rstIn     (rstIn),
        .set       (setPending),
        .setAddr   (issue.issueRd),
        .clear     (wbValid),
        .clearAddr (wbRd),
        .pending   (pending)
    );

    // Stall on a read of, or a write to, any register still waiting on a long-latency result.
    always_comb begin
        hazard = 1'b0;
        for (int p = 0; p < READ_PORT_COUNT; p++) begin
            if (issue.issueRsRead[p] && (issue.issueRs[p] != '0) && pending[issue.issueRs[p]]) begin
                hazard = 1'b1;
            end
        end
        if (issue.issueRdWrite && (issue.issueRd != '0) && pending[issue.issueRd]) begin
            hazard = 1'b1;
        end
    end

    assign issue.issueReady = !hazard;
    assign fire             = issue.issueValid && !hazard && !flush;
    assign setPending       = fire && issue.issueRdWrite && issue.issueLongLatency && (issue.issueRd != '0);
    assign bypassWrite      = fire && issue.issueRdWrite && !issue.issueLongLatency && (issue.issueRd != '0);

    // Bypass history shifts every cycle; a flush kills every tracked result at once.
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            for (int k = 0; k < BYPASS_DEPTH; k++) begin
                stages[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < BYPASS_DEPTH; k++) begin
                stages[k] <= '0;
            end
        end else begin
            stages[0].valid <= bypassWrite;
            stages[0].rd    <= issue.issueRd;
            for (int k = 1; k < BYPASS_DEPTH; k++) begin
                stages[k] <= stages[k-1];
            end
        end
    end

    // Priority encode per port: scanning oldest to youngest lets the youngest match win.
    always_comb begin
        selNext = '0;
        for (int p = 0; p < READ_PORT_COUNT; p++) begin
            for (int k = BYPASS_DEPTH - 1; k >= 0; k--) begin
                if (stages[k].valid && (stages[k].rd == issue.issueRs[p]) && (issue.issueRs[p] != '0)) begin
                    selNext[p] = BypassSel'(k + 1);
                end
            end
        end
    end

    assign issue.bypassSel = selNext;

    // Anything in flight, either a pending long-latency write or a live bypass stage.
    always_comb begin
        anyStageValid = 1'b0;
        for (int k = 0; k < BYPASS_DEPTH; k++) begin
            anyStageValid = anyStageValid | stages[k].valid;
        end
    end

    assign busy = (|pending) || anyStageValid;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios then random traffic.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    logic      clk = 1'b1;
    logic      rstIn = 1'b0;
    logic      flush = 1'b0;
    logic      wbValid = 1'b0;
    reg_addr_t wbRd = '0;
    logic      busy;

    hazard_controller_if hcIf();

    hazard_controller dut (
        .clk     (clk),
        .rstIn   (rstIn),
        .issue   (hcIf.slave),
        .flush   (flush),
        .wbValid (wbValid),
        .wbRd    (wbRd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        bit ready;
        int sel0;
        int sel1;
        bit busy;
    } Expect;

    Expect expQ[$];
    int    checks = 0;
    int    errors = 0;
    int    stepNo = 0;

    // Reference model: set of pending registers and a youngest-first history of bypassable writes.
    bit    pendModel [REG_FILE_SIZE];
    int    hist[$];

    function automatic int selFor(int rs);
        for (int k = 0; k < hist.size(); k++) begin
            if (rs != 0 && hist[k] == rs) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit modelBusy();
        for (int r = 0; r < REG_FILE_SIZE; r++) if (pendModel[r]) return 1'b1;
        for (int k = 0; k < hist.size(); k++) if (hist[k] != -1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic resetModel();
        for (int r = 0; r < REG_FILE_SIZE; r++) pendModel[r] = 1'b0;
        hist.delete();
        for (int k = 0; k < BYPASS_DEPTH; k++) hist.push_back(-1);
    endtask

    task automatic checkOutput(input string name, input int step, input logic [3:0] actual, input logic [3:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s step %0d actual %0d required %0d", name, step, actual, required);
        end
    endtask

    // Monitor: the DUT presents its combinational response every cycle; compare mid-cycle.
    always @(negedge clk) begin
        Expect e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("issueReady", e.step, {3'b0, hcIf.issueReady}, {3'b0, e.ready});
            checkOutput("bypassSel0", e.step, {2'b0, hcIf.bypassSel[0]}, 4'(e.sel0));
            checkOutput("bypassSel1", e.step, {2'b0, hcIf.bypassSel[1]}, 4'(e.sel1));
            checkOutput("busy", e.step, {3'b0, busy}, {3'b0, e.busy});
        end
    end

    task automatic applyStimulus(input logic v, input int r0, input int r1, input logic [1:0] rdRead,
                                 input int rd, input logic rw, input logic ll, input logic fl,
                                 input logic wv, input int wr);
        Expect e;
        bit    fire;
        hcIf.issueValid       = v;
        hcIf.issueRs[0]       = reg_addr_t'(r0);
        hcIf.issueRs[1]       = reg_addr_t'(r1);
        hcIf.issueRsRead      = rdRead;
        hcIf.issueRd          = reg_addr_t'(rd);
        hcIf.issueRdWrite     = rw;
        hcIf.issueLongLatency = ll;
        flush                 = fl;
        wbValid               = wv;
        wbRd                  = reg_addr_t'(wr);
        stepNo++;
        e.step  = stepNo;
        e.ready = 1'b1;
        if (rdRead[0] && r0 != 0 && pendModel[r0]) e.ready = 1'b0;
        if (rdRead[1] && r1 != 0 && pendModel[r1]) e.ready = 1'b0;
        if (rw && rd != 0 && pendModel[rd]) e.ready = 1'b0;
        e.sel0 = selFor(r0);
        e.sel1 = selFor(r1);
        e.busy = modelBusy();
        expQ.push_back(e);
        fire = v && e.ready && !fl;
        @(posedge clk);
        if (rstIn) begin
            if (fl) begin
                for (int k = 0; k < hist.size(); k++) hist[k] = -1;
            end else begin
                hist.push_front((fire && rw && !ll && rd != 0) ? rd : -1);
                void'(hist.pop_back());
            end
            if (wv) pendModel[wr] = 1'b0;
            if (fire && rw && ll && rd != 0) pendModel[rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pendList[$];
        resetModel();
        rstIn = 1'b0;
        idle(2);
        rstIn = 1'b1;

        // After reset: plain consumer of x5/x6.
        applyStimulus(1, 5, 6, 2'b11, 0, 0, 0, 0, 0, 0);

        // ALU rd=3 then consumer for three cycles: 1, 2, then register file.
        applyStimulus(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);

        // Two ALU writes to x7 back to back; youngest wins on port 1.
        applyStimulus(1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0);

        // Load x4, consumer stalls, writeback releases one cycle later.
        applyStimulus(1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0);
        applyStimulus(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 0, 2'b01, 0, 0, 0, 0, 1, 4);
        applyStimulus(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0);

        // WAW on pending x9 with no sources read.
        applyStimulus(1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 9, 1, 0, 0, 1, 9);
        applyStimulus(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0);
        idle(3);

        // Load x10 pending, ALU x2 then flush; bypass gone, pending survives.
        applyStimulus(1, 0, 0, 2'b00, 10, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 2, 1, 0, 0, 0, 0);
        applyStimulus(0, 2, 0, 2'b01, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 2, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 10);
        idle(2);

        // Random traffic over a small register window to provoke matches and hazards.
        for (int i = 0; i < 600; i++) begin
            logic wv;
            int   wr;
            pendList.delete();
            for (int r = 1; r < 8; r++) if (pendModel[r]) pendList.push_back(r);
            wv = 1'b0;
            wr = int'($urandom_range(0, 7));
            if (pendList.size() > 0 && $urandom_range(0, 1) == 1) begin
                wv = 1'b1;
                wr = pendList[$urandom_range(0, pendList.size() - 1)];
            end else if ($urandom_range(0, 9) == 0) begin
                wv = 1'b1;
            end
            applyStimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), wv, wr);
            if (i == 300) begin
                rstIn = 1'b0;
                resetModel();
                idle(1);
                rstIn = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual %0d required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
